// File: rtl/tff_pkg.sv
// Shared constants and helpers for the T flip-flop bank and its board-rate divider.
package tff_pkg;

    localparam int MODE_BANK  = 0;
    localparam int MODE_CHAIN = 1;

    // Counter width needed to hold values 0..value-1. Never returns less than 1.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/tff_bank_tick_gen.sv
// Clock-enable divider: strobes tick once every DIV_COUNT+1 enabled clk cycles.
module tick_gen #(
    parameter int DIV_COUNT = 49_999_999,
    parameter int CNT_W     = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV_COUNT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Decoded from the registered count so tick is glitch-free relative to clk.
    assign tick = en & ~clr & (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tff_bank.sv
// WIDTH-channel T flip-flop bank stepped by a divided tick; MODE selects independent bits or counter.
// Define TFF_BANK_EDGE_EN to turn each t[i] into a synchronized, edge-latched press request.
module tff_bank
    import tff_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_COUNT = 49_999_999,
    parameter int CNT_W     = clog2_min1(DIV_COUNT + 1),
    parameter int MODE      = MODE_BANK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tick,
    output logic             wrap
);

    logic [WIDTH-1:0] t_eff;
    logic [WIDTH-1:0] tg;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             carry;

    tick_gen #(
        .DIV_COUNT (DIV_COUNT),
        .CNT_W     (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .tick  (tick)
    );

`ifdef TFF_BANK_EDGE_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] rise;

    assign rise  = sync2_q & ~prev_q;
    assign t_eff = pending_q;

    // Only bits actually used by tg are consumed; an edge seen this cycle survives the tick.
    always_comb begin
        pending_d = pending_q | rise;
        if (clr) begin
            pending_d = '0;
        end else if (tick) begin
            pending_d = (pending_q & ~tg) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= t;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end
`else
    assign t_eff = t;
`endif

    // In chain mode a bit toggles only when every lower bit is already one.
    always_comb begin
        tg    = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tg[i] = t_eff[i] & carry;
            carry = carry & q_q[i];
        end
        if (MODE != MODE_CHAIN) begin
            tg = t_eff;
        end
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (tick) begin
            q_d    = q_q ^ tg;
            wrap_d = (MODE == MODE_CHAIN) && (&q_q) && (q_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign qb   = ~q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_bank.sv
// Scoreboard bench for tff_bank: a MODE 0 and a MODE 1 instance share one stimulus stream.
module tb_tff_bank;

    localparam int W   = 4;
    localparam int DIV = 3;
    localparam int EW  = 19;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         clr = 1'b0;
    logic [W-1:0] t = '0;

    logic [W-1:0] q0, qb0, q1, qb1;
    logic         tick0, tick1, wrap0, wrap1;

    int n_vec = 0;
    int miscompares = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    int           m_cnt;
    logic [W-1:0] m_q0, m_q1;
    logic         m_w1;
    logic [W-1:0] m_s1, m_s2, m_s3, m_p0, m_p1;

    always #5 clk = ~clk;

    tff_bank #(.WIDTH(W), .DIV_COUNT(DIV), .MODE(0)) u_bank (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .t(t),
        .q(q0), .qb(qb0), .tick(tick0), .wrap(wrap0)
    );

    tff_bank #(.WIDTH(W), .DIV_COUNT(DIV), .MODE(1)) u_chain (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .t(t),
        .q(q1), .qb(qb1), .tick(tick1), .wrap(wrap1)
    );

    function automatic logic [EW-1:0] actual_vec();
        return {tick0 & tick1, q0, qb0, wrap0, q1, qb1, wrap1};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_q0 = '0; m_q1 = '0; m_w1 = 1'b0;
        m_s1 = '0; m_s2 = '0; m_s3 = '0; m_p0 = '0; m_p1 = '0;
    endtask

    // Expected outputs for the current cycle, then state after the coming edge.
    task automatic push_and_advance();
        logic         m_tick;
        logic [W-1:0] te0, te1, tg1, nq1, rise;
        int           qv;
        m_tick = en && !clr && (m_cnt == DIV);
        exp_q.push_back({m_tick, m_q0, ~m_q0, 1'b0, m_q1, ~m_q1, m_w1});
`ifdef TFF_BANK_EDGE_EN
        te0 = m_p0;
        te1 = m_p1;
        rise = m_s2 & ~m_s3;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = t;
`else
        te0 = t;
        te1 = t;
        rise = '0;
`endif
        qv = int'(m_q1);
        for (int i = 0; i < W; i++) begin
            tg1[i] = te1[i] && ((qv % (1 << i)) == ((1 << i) - 1));
        end
        if (clr) begin
            m_q0 = '0; m_q1 = '0; m_w1 = 1'b0; m_cnt = 0; m_p0 = '0; m_p1 = '0;
        end else if (m_tick) begin
            nq1  = m_q1 ^ tg1;
            m_w1 = (m_q1 == 4'hF) && (nq1 == 4'h0);
            m_q0 = m_q0 ^ te0;
            m_q1 = nq1;
            m_cnt = 0;
            m_p0 = (m_p0 & ~te0) | rise;
            m_p1 = (m_p1 & ~tg1) | rise;
        end else begin
            m_w1 = 1'b0;
            if (en) m_cnt = m_cnt + 1;
            m_p0 = m_p0 | rise;
            m_p1 = m_p1 | rise;
        end
    endtask

    task automatic cyc(input logic e, input logic c, input logic [W-1:0] tv);
        @(posedge clk);
        #1;
        en = e; clr = c; t = tv;
        push_and_advance();
    endtask

    // Reset is pulsed between edges and checked before any clk edge can occur.
    task automatic reset_pulse();
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        got  = actual_vec();
        want = {1'b0, 4'h0, 4'hF, 1'b0, 4'h0, 4'hF, 1'b0};
        n_vec++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL async_reset t=%0t got=%h want=%h", $time, got, want);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        push_and_advance();
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] want;
        logic [EW-1:0] got;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = actual_vec();
            n_vec++;
            if (got !== want || tick0 !== tick1) begin
                miscompares++;
                $display("FAIL cycle t=%0t {tick,q0,qb0,wrap0,q1,qb1,wrap1} got=%h want=%h tick0=%b tick1=%b",
                         $time, got, want, tick0, tick1);
            end
        end
    end

    task automatic bound_fail(input string what);
        n_vec++;
        miscompares++;
        $display("FAIL %s bound expired t=%0t cnt=%0d q1=%h", what, $time, m_cnt, m_q1);
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (2) @(posedge clk);

        // 1: idle after reset, ticks every 4 cycles, q stays 0
        reset_pulse();
        repeat (14) cyc(1'b1, 1'b0, 4'h0);

        // 2: bank toggles 0101 pattern
        reset_pulse();
        repeat (12) cyc(1'b1, 1'b0, 4'h5);

        // 3: full counter sweep with wrap
        reset_pulse();
        repeat (70) cyc(1'b1, 1'b0, 4'hF);

        // 4: freeze at cnt==2 for 10 cycles
        guard = 0;
        while (m_cnt != 2 && guard < 20) begin
            cyc(1'b1, 1'b0, 4'hF);
            guard++;
        end
        if (m_cnt != 2) bound_fail("reach_cnt2");
        repeat (10) cyc(1'b0, 1'b0, 4'hF);
        repeat (12) cyc(1'b1, 1'b0, 4'hF);

        // 5: clr in a tick cycle with q1 == 0111
        reset_pulse();
        guard = 0;
        while (!(m_q1 == 4'h7 && m_cnt == DIV) && guard < 200) begin
            cyc(1'b1, 1'b0, 4'hF);
            guard++;
        end
        if (!(m_q1 == 4'h7 && m_cnt == DIV)) bound_fail("reach_q7_tick");
        cyc(1'b1, 1'b1, 4'hF);
        repeat (6) cyc(1'b1, 1'b0, 4'hF);

`ifdef TFF_BANK_EDGE_EN
        // 6: single-cycle press and a long hold each toggle once
        reset_pulse();
        repeat (2) cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h4);
        repeat (10) cyc(1'b1, 1'b0, 4'h0);
        repeat (14) cyc(1'b1, 1'b0, 4'h4);
        repeat (8) cyc(1'b1, 1'b0, 4'h0);
`endif

        // randomized traffic with occasional freezes, clears and mid-run resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse();
            end else begin
                cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                    W'($urandom_range(0, 15)));
            end
        end
        repeat (4) cyc(1'b1, 1'b0, 4'h0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) bound_fail("drain");
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
